// File: rtl/nasti_mem_bridge_pkg.sv
// nasti_mem_bridge_pkg: bridge FSM states, NASTI burst/response encodings and the
// beat-size helper shared by the line bridge and its line buffer.
package nasti_mem_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAw,
      StW,
      StB,
      StAr,
      StR,
      StResp
   } bridge_state_e;

   localparam logic [1:0] NASTI_BURST_INCR  = 2'b01;
   localparam logic [1:0] NASTI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] NASTI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] NASTI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] NASTI_RESP_DECERR = 2'b11;

   // AxSIZE encoding for a beat of data_width bits.
   function automatic logic [2:0] nasti_size(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/nasti_line_buf.sv
// nasti_line_buf: LINE_BEATS x DATA_WIDTH line register with a single-beat write port,
// full-line load/read and a saturating beat counter shared by the W and R paths.
module nasti_line_buf
   import nasti_mem_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned LINE_BEATS = 4,
   localparam int unsigned IDX_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
   localparam int unsigned CNT_W     = $clog2(LINE_BEATS) + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic [LINE_BEATS*DATA_WIDTH-1:0] load_line,
   input  logic                             wr_en,
   input  logic [IDX_W-1:0]                 wr_idx,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic                             cnt_clr,
   input  logic                             cnt_inc,
   output logic [CNT_W-1:0]                 cnt,
   output logic                             cnt_last,
   output logic                             cnt_over,
   output logic [DATA_WIDTH-1:0]            beat,
   output logic [LINE_BEATS*DATA_WIDTH-1:0] line
);

   logic [DATA_WIDTH-1:0] mem_q [LINE_BEATS];
   logic [CNT_W-1:0]      cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LINE_BEATS; i++) mem_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < LINE_BEATS; i++) mem_q[i] <= load_line[i*DATA_WIDTH +: DATA_WIDTH];
         end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
         end
         // Counter parks one past the last beat so overlong bursts stay detectable.
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc && !cnt_over) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign cnt      = cnt_q;
   assign cnt_last = (cnt_q == CNT_W'(LINE_BEATS - 1));
   assign cnt_over = (cnt_q == CNT_W'(LINE_BEATS));
   assign beat     = cnt_over ? '0 : mem_q[cnt_q[IDX_W-1:0]];

   always_comb begin
      line = '0;
      for (int i = 0; i < LINE_BEATS; i++) line[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
   end

endmodule

// File: rtl/nasti_mem_bridge.sv
// nasti_mem_bridge: one-line-per-request NASTI master (flattened nasti_channel master end),
// one outstanding INCR burst. Define NASTI_MEM_BRIDGE_STRB_EN for per-byte write strobes.
module nasti_mem_bridge
   import nasti_mem_bridge_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 1,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned LINE_BEATS = 4,
   parameter int unsigned ID_VALUE   = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [LINE_BEATS*DATA_WIDTH-1:0] req_wdata,
`ifdef NASTI_MEM_BRIDGE_STRB_EN
   input  logic [LINE_BEATS*DATA_WIDTH/8-1:0] req_wstrb,
`endif
   output logic                             resp_valid,
   input  logic                             resp_ready,
   output logic [LINE_BEATS*DATA_WIDTH-1:0] resp_rdata,
   output logic                             resp_err,
   output logic                             aw_valid,
   input  logic                             aw_ready,
   output logic [ID_WIDTH-1:0]              aw_id,
   output logic [ADDR_WIDTH-1:0]            aw_addr,
   output logic [7:0]                       aw_len,
   output logic [2:0]                       aw_size,
   output logic [1:0]                       aw_burst,
   output logic                             aw_lock,
   output logic [3:0]                       aw_cache,
   output logic [2:0]                       aw_prot,
   output logic [3:0]                       aw_qos,
   output logic [3:0]                       aw_region,
   output logic [USER_WIDTH-1:0]            aw_user,
   output logic                             w_valid,
   input  logic                             w_ready,
   output logic [DATA_WIDTH-1:0]            w_data,
   output logic [DATA_WIDTH/8-1:0]          w_strb,
   output logic                             w_last,
   output logic [USER_WIDTH-1:0]            w_user,
   input  logic                             b_valid,
   output logic                             b_ready,
   input  logic [ID_WIDTH-1:0]              b_id,
   input  logic [1:0]                       b_resp,
   input  logic [USER_WIDTH-1:0]            b_user,
   output logic                             ar_valid,
   input  logic                             ar_ready,
   output logic [ID_WIDTH-1:0]              ar_id,
   output logic [ADDR_WIDTH-1:0]            ar_addr,
   output logic [7:0]                       ar_len,
   output logic [2:0]                       ar_size,
   output logic [1:0]                       ar_burst,
   output logic                             ar_lock,
   output logic [3:0]                       ar_cache,
   output logic [2:0]                       ar_prot,
   output logic [3:0]                       ar_qos,
   output logic [3:0]                       ar_region,
   output logic [USER_WIDTH-1:0]            ar_user,
   input  logic                             r_valid,
   output logic                             r_ready,
   input  logic [ID_WIDTH-1:0]              r_id,
   input  logic [DATA_WIDTH-1:0]            r_data,
   input  logic [1:0]                       r_resp,
   input  logic                             r_last,
   input  logic [USER_WIDTH-1:0]            r_user
);

   localparam int unsigned LINE_W = LINE_BEATS * DATA_WIDTH;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
   localparam int unsigned IDX_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int unsigned CNT_W  = $clog2(LINE_BEATS) + 1;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
   localparam logic [ID_WIDTH-1:0]   ID        = ID_WIDTH'(ID_VALUE);
   localparam logic [7:0]            LEN       = 8'(LINE_BEATS - 1);
   localparam logic [2:0]            SIZE      = nasti_size(DATA_WIDTH);

   bridge_state_e           state_q, state_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    accept;
   logic                    buf_load, buf_wr, cnt_clr, cnt_inc;
   logic [CNT_W-1:0]        cnt;
   logic                    cnt_last, cnt_over;
   logic [DATA_WIDTH-1:0]   beat;
   logic [STRB_W-1:0]       beat_strb;
   logic                    b_bad, r_bad;
   logic                    unused_ok;

   nasti_line_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_BEATS (LINE_BEATS)
   ) u_line_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .load_line (req_wdata),
      .wr_en     (buf_wr),
      .wr_idx    (cnt[IDX_W-1:0]),
      .wr_data   (r_data),
      .cnt_clr   (cnt_clr),
      .cnt_inc   (cnt_inc),
      .cnt       (cnt),
      .cnt_last  (cnt_last),
      .cnt_over  (cnt_over),
      .beat      (beat),
      .line      (resp_rdata)
   );

   assign b_bad = (b_resp == NASTI_RESP_SLVERR) || (b_resp == NASTI_RESP_DECERR) || (b_id != ID);
   assign r_bad = (r_resp == NASTI_RESP_SLVERR) || (r_resp == NASTI_RESP_DECERR) || (r_id != ID);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      addr_d     = addr_q;
      accept     = 1'b0;
      buf_load   = 1'b0;
      buf_wr     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      req_ready  = 1'b0;
      aw_valid   = 1'b0;
      w_valid    = 1'b0;
      b_ready    = 1'b0;
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         StIdle: begin
            // Held low while rst is high so every output reads 0 during reset.
            req_ready = !rst;
            if (req_valid && !rst) begin
               accept   = 1'b1;
               addr_d   = req_addr & LINE_MASK;
               err_d    = 1'b0;
               cnt_clr  = 1'b1;
               buf_load = req_write;
               state_d  = req_write ? StAw : StAr;
            end
         end
         StAw: begin
            aw_valid = 1'b1;
            if (aw_ready) state_d = StW;
         end
         StW: begin
            w_valid = 1'b1;
            if (w_ready) begin
               if (cnt_last) state_d = StB;
               else          cnt_inc = 1'b1;
            end
         end
         StB: begin
            b_ready = 1'b1;
            if (b_valid) begin
               err_d   = err_q | b_bad;
               state_d = StResp;
            end
         end
         StAr: begin
            ar_valid = 1'b1;
            if (ar_ready) state_d = StR;
         end
         StR: begin
            r_ready = 1'b1;
            if (r_valid) begin
               // Beats past the line end are acknowledged but dropped.
               if (cnt_over) err_d = 1'b1;
               else          buf_wr = 1'b1;
               if (r_bad) err_d = 1'b1;
               if (r_last) begin
                  if (!cnt_last) err_d = 1'b1;
                  state_d = StResp;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         StResp: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef NASTI_MEM_BRIDGE_STRB_EN
   logic [LINE_W/8-1:0] strb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         strb_q <= '0;
      end else if (accept) begin
         strb_q <= req_wstrb;
      end
   end

   assign beat_strb = strb_q[int'(cnt[IDX_W-1:0]) * STRB_W +: STRB_W];
`else
   assign beat_strb = '1;
`endif

   assign resp_err  = (state_q == StResp) && err_q;

   assign aw_id     = aw_valid ? ID : '0;
   assign aw_addr   = aw_valid ? addr_q : '0;
   assign aw_len    = aw_valid ? LEN : '0;
   assign aw_size   = aw_valid ? SIZE : '0;
   assign aw_burst  = aw_valid ? NASTI_BURST_INCR : '0;
   assign aw_lock   = 1'b0;
   assign aw_cache  = '0;
   assign aw_prot   = '0;
   assign aw_qos    = '0;
   assign aw_region = '0;
   assign aw_user   = '0;

   assign w_data    = w_valid ? beat : '0;
   assign w_strb    = w_valid ? beat_strb : '0;
   assign w_last    = w_valid && cnt_last;
   assign w_user    = '0;

   assign ar_id     = ar_valid ? ID : '0;
   assign ar_addr   = ar_valid ? addr_q : '0;
   assign ar_len    = ar_valid ? LEN : '0;
   assign ar_size   = ar_valid ? SIZE : '0;
   assign ar_burst  = ar_valid ? NASTI_BURST_INCR : '0;
   assign ar_lock   = 1'b0;
   assign ar_cache  = '0;
   assign ar_prot   = '0;
   assign ar_qos    = '0;
   assign ar_region = '0;
   assign ar_user   = '0;

   assign unused_ok = ^{b_user, r_user, cnt[CNT_W-1], accept};

endmodule

// File: tb/tb_nasti_mem_bridge.sv
// tb_nasti_mem_bridge: directed vector table plus hand sequences for reset and strobes.
module tb_nasti_mem_bridge;

   localparam int unsigned IDW = 1;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 128;
   localparam int unsigned UW  = 1;
   localparam int unsigned LB  = 4;
   localparam int unsigned LW  = LB * DW;
   localparam int unsigned SB  = DW / 8;

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [7:0]  base;
      logic [1:0]  bresp;
      logic [1:0]  rresp;
      logic        bad_id;
      int          n_beats;
      int          stall;
      int          hold;
      logic [15:0] exp_addr;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_wdata;
   logic [LW/8-1:0] wstrb_drv;
   logic resp_valid, resp_ready, resp_err;
   logic [LW-1:0] resp_rdata;
   logic aw_valid, aw_ready, aw_lock, w_valid, w_ready, w_last;
   logic [IDW-1:0] aw_id, b_id, ar_id, r_id;
   logic [AW-1:0] aw_addr, ar_addr;
   logic [7:0] aw_len, ar_len;
   logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
   logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
   logic [3:0] aw_cache, aw_qos, aw_region, ar_cache, ar_qos, ar_region;
   logic [UW-1:0] aw_user, w_user, b_user, ar_user, r_user;
   logic [DW-1:0] w_data, r_data;
   logic [SB-1:0] w_strb;
   logic b_valid, b_ready, ar_valid, ar_ready, ar_lock, r_valid, r_ready, r_last;

   int n_cmp = 0;
   int n_err = 0;
   logic [LW-1:0] model_line;
   vec_t vecs [12];
   vec_t post;

   always #5 clk = ~clk;

   nasti_mem_bridge #(
      .ID_WIDTH (IDW), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .USER_WIDTH (UW),
      .LINE_BEATS (LB), .ID_VALUE (0)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
      .req_addr (req_addr), .req_wdata (req_wdata),
`ifdef NASTI_MEM_BRIDGE_STRB_EN
      .req_wstrb (wstrb_drv),
`endif
      .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_rdata (resp_rdata),
      .resp_err (resp_err),
      .aw_valid (aw_valid), .aw_ready (aw_ready), .aw_id (aw_id), .aw_addr (aw_addr),
      .aw_len (aw_len), .aw_size (aw_size), .aw_burst (aw_burst), .aw_lock (aw_lock),
      .aw_cache (aw_cache), .aw_prot (aw_prot), .aw_qos (aw_qos), .aw_region (aw_region),
      .aw_user (aw_user),
      .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data), .w_strb (w_strb),
      .w_last (w_last), .w_user (w_user),
      .b_valid (b_valid), .b_ready (b_ready), .b_id (b_id), .b_resp (b_resp), .b_user (b_user),
      .ar_valid (ar_valid), .ar_ready (ar_ready), .ar_id (ar_id), .ar_addr (ar_addr),
      .ar_len (ar_len), .ar_size (ar_size), .ar_burst (ar_burst), .ar_lock (ar_lock),
      .ar_cache (ar_cache), .ar_prot (ar_prot), .ar_qos (ar_qos), .ar_region (ar_region),
      .ar_user (ar_user),
      .r_valid (r_valid), .r_ready (r_ready), .r_id (r_id), .r_data (r_data), .r_resp (r_resp),
      .r_last (r_last), .r_user (r_user)
   );

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] bv(input logic [7:0] base, input int k);
      logic [7:0] b;
      b = base + 8'(k);
      return {(DW/8){b}};
   endfunction

   function automatic logic [LW-1:0] make_line(input logic [7:0] base);
      logic [LW-1:0] l;
      for (int k = 0; k < LB; k++) l[k*DW +: DW] = bv(base, k);
      return l;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d", idx);
      chk({p, " req_ready idle"}, req_ready, 1);
      req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = make_line(v.base);
      tick;
      req_valid = 1'b0; req_wdata = '0;
      chk({p, " req_ready busy"}, req_ready, 0);
      if (v.write) begin
         model_line = make_line(v.base);
         chk({p, " aw_valid"}, aw_valid, 1);
         chk({p, " aw_addr"}, aw_addr, v.exp_addr);
         chk({p, " aw_len/size/burst"}, {aw_len, aw_size, aw_burst}, {8'd3, 3'd4, 2'd1});
         chk({p, " aw_cache/prot/lock"}, {aw_cache, aw_prot, aw_lock, aw_id}, 0);
         chk({p, " ar_valid"}, ar_valid, 0);
         tick;
         for (int k = 0; k < LB; k++) begin
            chk($sformatf("%s w_valid b%0d", p, k), w_valid, 1);
            chk($sformatf("%s w_last b%0d", p, k), w_last, (k == LB - 1));
            chk($sformatf("%s w_data b%0d", p, k), w_data, bv(v.base, k));
            chk($sformatf("%s w_strb b%0d", p, k), w_strb, wstrb_drv[k*SB +: SB]);
            tick;
         end
         chk({p, " w_valid after"}, w_valid, 0);
         chk({p, " b_ready"}, b_ready, 1);
         b_valid = 1'b1; b_resp = v.bresp; b_id = v.bad_id;
         tick;
         b_valid = 1'b0; b_resp = '0; b_id = '0;
      end else begin
         chk({p, " ar_valid"}, ar_valid, 1);
         chk({p, " ar_addr"}, ar_addr, v.exp_addr);
         chk({p, " ar_len/size/burst"}, {ar_len, ar_size, ar_burst}, {8'd3, 3'd4, 2'd1});
         chk({p, " aw_valid"}, aw_valid, 0);
         tick;
         for (int i = 0; i < v.n_beats; i++) begin
            for (int s = 0; s < v.stall; s++) begin
               tick;
               chk($sformatf("%s ar_valid stall%0d", p, s), ar_valid, 0);
            end
            r_valid = 1'b1; r_data = bv(v.base, i); r_last = (i == v.n_beats - 1);
            r_resp = v.rresp; r_id = v.bad_id;
            chk($sformatf("%s r_ready b%0d", p, i), r_ready, 1);
            if (i < LB) model_line[i*DW +: DW] = bv(v.base, i);
            tick;
            r_valid = 1'b0; r_last = 1'b0; r_resp = '0; r_id = '0;
         end
      end
      chk({p, " resp_valid"}, resp_valid, 1);
      chk({p, " resp_err"}, resp_err, v.exp_err);
      if (!v.write) chk({p, " resp_rdata"}, resp_rdata, model_line);
      for (int h = 0; h < v.hold; h++) begin
         req_valid = 1'b1;
         tick;
         chk($sformatf("%s held resp_valid h%0d", p, h), resp_valid, 1);
         chk($sformatf("%s held rdata h%0d", p, h), resp_rdata, model_line);
         chk($sformatf("%s held req_ready h%0d", p, h), req_ready, 0);
         chk($sformatf("%s held aw/ar h%0d", p, h), {aw_valid, ar_valid}, 0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk({p, " resp_valid drop"}, resp_valid, 0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      wstrb_drv = '1; resp_ready = 1'b0;
      aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
      b_valid = 1'b0; b_id = '0; b_resp = '0; b_user = '0;
      r_valid = 1'b0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b0; r_user = '0;
      model_line = '0;

      //      wr    addr     base   bresp  rresp  badid nb st hold exp_addr  err
      vecs[0]  = '{1'b1, 16'h1234, 8'h10, 2'b00, 2'b00, 1'b0, 4, 0, 0, 16'h1200, 1'b0};
      vecs[1]  = '{1'b0, 16'h1234, 8'hA0, 2'b00, 2'b00, 1'b0, 4, 0, 0, 16'h1200, 1'b0};
      vecs[2]  = '{1'b0, 16'h2FFF, 8'h50, 2'b00, 2'b00, 1'b0, 4, 5, 0, 16'h2FC0, 1'b0};
      vecs[3]  = '{1'b1, 16'h0040, 8'h20, 2'b10, 2'b00, 1'b0, 4, 0, 0, 16'h0040, 1'b1};
      vecs[4]  = '{1'b0, 16'h0000, 8'hC0, 2'b00, 2'b00, 1'b0, 4, 0, 0, 16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 16'h0100, 8'hB0, 2'b00, 2'b00, 1'b0, 2, 0, 0, 16'h0100, 1'b1};
      vecs[6]  = '{1'b0, 16'h0200, 8'hD0, 2'b00, 2'b00, 1'b0, 6, 0, 0, 16'h0200, 1'b1};
      vecs[7]  = '{1'b0, 16'h0300, 8'hE0, 2'b00, 2'b10, 1'b0, 4, 0, 0, 16'h0300, 1'b1};
      vecs[8]  = '{1'b1, 16'hFFFF, 8'h30, 2'b00, 2'b00, 1'b1, 4, 0, 0, 16'hFFC0, 1'b1};
      vecs[9]  = '{1'b0, 16'h8040, 8'h60, 2'b00, 2'b00, 1'b0, 4, 0, 10, 16'h8040, 1'b0};
      vecs[10] = '{1'b1, 16'h7777, 8'h70, 2'b11, 2'b00, 1'b0, 4, 0, 0, 16'h7740, 1'b1};
      vecs[11] = '{1'b0, 16'h4321, 8'h80, 2'b00, 2'b01, 1'b0, 4, 0, 0, 16'h4300, 1'b0};
      post     = '{1'b0, 16'h1010, 8'h90, 2'b00, 2'b00, 1'b0, 4, 0, 0, 16'h1000, 1'b0};

      @(negedge clk);
      tick; tick; tick;
      chk("reset outputs", {req_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready,
          resp_valid, resp_err, aw_len, ar_len, aw_size, w_strb, w_last}, 0);
      chk("reset rdata", resp_rdata, 0);
      rst = 1'b0;
      #1;
      chk("req_ready after reset", req_ready, 1);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a read burst, two of four beats in.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3000;
      tick;
      req_valid = 1'b0;
      tick;
      for (int i = 0; i < 2; i++) begin
         r_valid = 1'b1; r_data = bv(8'hF0, i);
         tick;
      end
      r_valid = 1'b0;
      chk("mid-R r_ready", r_ready, 1);
      rst = 1'b1;
      tick;
      chk("mid-R reset valids", {aw_valid, w_valid, ar_valid, r_ready, b_ready, resp_valid,
          req_ready}, 0);
      chk("mid-R reset rdata", resp_rdata, 0);
      tick; tick;
      rst = 1'b0;
      #1;
      chk("mid-R req_ready after", req_ready, 1);
      model_line = '0;
      run_vec(12, post);

`ifdef NASTI_MEM_BRIDGE_STRB_EN
      wstrb_drv = {{(LW/8-16){1'b1}}, 16'h000F};
      run_vec(13, '{1'b1, 16'h0500, 8'h44, 2'b00, 2'b00, 1'b0, 4, 0, 0, 16'h0500, 1'b0});
      wstrb_drv = '1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
